// File: rtl/timestamp_capture.sv
// Prescaled free-running mission timestamp with N_CH independent rising-edge capture channels.
// Each channel latches the current TIMESTAMP on a request edge and holds it until acknowledged.
module timestamp_capture #(
    parameter int unsigned TS_WIDTH  = 24,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WRAP_MODE = 1,
    parameter int unsigned OVERWRITE = 0
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     EN,
    input  logic                     LOAD,
    input  logic [TS_WIDTH-1:0]      LOAD_VAL,
    input  logic [N_CH-1:0]          CAP_REQ,
    input  logic [N_CH-1:0]          CAP_ACK,
    output logic [TS_WIDTH-1:0]      TIMESTAMP,
    output logic                     TICK,
    output logic                     ROLLOVER,
    output logic [N_CH-1:0]          CAP_VALID,
    output logic [N_CH-1:0]          CAP_OVF,
    output logic [N_CH*TS_WIDTH-1:0] CAP_DATA
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [TS_WIDTH-1:0] TS_MAX   = '1;
    localparam bit                  WRAP     = (WRAP_MODE != 0);
    localparam bit                  OVW      = (OVERWRITE != 0);

    logic [PRE_W-1:0] pre_cnt;
    logic [N_CH-1:0]  req_q;
    logic [N_CH-1:0]  req_edge_c;
    logic             pre_last_c;
    logic             ts_max_c;

    assign pre_last_c = (pre_cnt == PRE_LAST);
    assign ts_max_c   = (TIMESTAMP == TS_MAX);
    assign req_edge_c = CAP_REQ & ~req_q;

    // Time base: LOAD beats the prescaled increment; TICK/ROLLOVER align with the new value.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pre_cnt   <= '0;
            TIMESTAMP <= '0;
            TICK      <= 1'b0;
            ROLLOVER  <= 1'b0;
        end else if (LOAD) begin
            pre_cnt   <= '0;
            TIMESTAMP <= LOAD_VAL;
            TICK      <= 1'b0;
            ROLLOVER  <= 1'b0;
        end else begin
            TICK     <= 1'b0;
            ROLLOVER <= 1'b0;
            if (EN) begin
                if (pre_last_c) begin
                    pre_cnt <= '0;
                    TICK    <= 1'b1;
                    if (!ts_max_c) begin
                        TIMESTAMP <= TIMESTAMP + TS_WIDTH'(1);
                    end else if (WRAP) begin
                        TIMESTAMP <= '0;
                        ROLLOVER  <= 1'b1;
                    end
                end else begin
                    pre_cnt <= pre_cnt + PRE_W'(1);
                end
            end
        end
    end

    // Request history resets high so a request held through reset needs a fresh edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_q <= '1;
        end else begin
            req_q <= CAP_REQ;
        end
    end

    // Capture channels sample the pre-increment, pre-load TIMESTAMP of the edge cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CAP_VALID <= '0;
            CAP_OVF   <= '0;
            CAP_DATA  <= '0;
        end else begin
            for (int i = 0; i < int'(N_CH); i++) begin
                if (req_edge_c[i]) begin
                    if (!CAP_VALID[i] || CAP_ACK[i]) begin
                        CAP_DATA[i*TS_WIDTH +: TS_WIDTH] <= TIMESTAMP;
                        CAP_VALID[i]                     <= 1'b1;
                        CAP_OVF[i]                       <= 1'b0;
                    end else begin
                        CAP_OVF[i] <= 1'b1;
                        if (OVW) begin
                            CAP_DATA[i*TS_WIDTH +: TS_WIDTH] <= TIMESTAMP;
                        end
                    end
                end else if (CAP_ACK[i]) begin
                    CAP_VALID[i] <= 1'b0;
                    CAP_OVF[i]   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed bench for timestamp_capture: two instances share stimulus, one wrapping/keep-old,
// one saturating/overwrite, so both parameter corners are checked in a single run.
module tb_timestamp_capture;

    logic        CLK;
    logic        RESET;
    logic        EN;
    logic        LOAD;
    logic [7:0]  LOAD_VAL;
    logic [1:0]  CAP_REQ;
    logic [1:0]  CAP_ACK;

    logic [7:0]  ts_a, ts_b;
    logic        tick_a, tick_b, roll_a, roll_b;
    logic [1:0]  valid_a, valid_b, ovf_a, ovf_b;
    logic [15:0] data_a, data_b;

    integer checks;
    integer failures;

    timestamp_capture #(
        .TS_WIDTH(8), .PRESCALE(4), .N_CH(2), .WRAP_MODE(1), .OVERWRITE(0)
    ) dut_a (
        .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .CAP_REQ(CAP_REQ), .CAP_ACK(CAP_ACK), .TIMESTAMP(ts_a), .TICK(tick_a),
        .ROLLOVER(roll_a), .CAP_VALID(valid_a), .CAP_OVF(ovf_a), .CAP_DATA(data_a)
    );

    timestamp_capture #(
        .TS_WIDTH(8), .PRESCALE(4), .N_CH(2), .WRAP_MODE(0), .OVERWRITE(1)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
        .CAP_REQ(CAP_REQ), .CAP_ACK(CAP_ACK), .TIMESTAMP(ts_b), .TICK(tick_b),
        .ROLLOVER(roll_b), .CAP_VALID(valid_b), .CAP_OVF(ovf_b), .CAP_DATA(data_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        ld;
        logic [7:0]  ld_val;
        logic [1:0]  req;
        logic [1:0]  ack;
        logic [7:0]  ts;
        logic [1:0]  valid;
        logic [1:0]  ovf;
        logic [15:0] da;
        logic [15:0] db;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_chan(input string nm, input logic [1:0] v, input logic [1:0] o,
                              input logic [15:0] da, input logic [15:0] db);
        check({nm, " valid_a"}, 32'(valid_a), 32'(v));
        check({nm, " valid_b"}, 32'(valid_b), 32'(v));
        check({nm, " ovf_a"}, 32'(ovf_a), 32'(o));
        check({nm, " ovf_b"}, 32'(ovf_b), 32'(o));
        check({nm, " data_a"}, 32'(data_a), 32'(da));
        check({nm, " data_b"}, 32'(data_b), 32'(db));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        EN       = 1'b0;
        LOAD     = 1'b0;
        LOAD_VAL = 8'h00;
        CAP_REQ  = 2'b00;
        CAP_ACK  = 2'b00;

        // Capture table, run with EN=0 so TIMESTAMP moves only by LOAD.
        vecs[0]  = '{1'b1, 8'h05, 2'b00, 2'b00, 8'h05, 2'b00, 2'b00, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 8'h00, 2'b01, 2'b00, 8'h05, 2'b01, 2'b00, 16'h0005, 16'h0005};
        vecs[2]  = '{1'b0, 8'h00, 2'b01, 2'b01, 8'h05, 2'b00, 2'b00, 16'h0005, 16'h0005};
        vecs[3]  = '{1'b1, 8'h03, 2'b00, 2'b00, 8'h03, 2'b00, 2'b00, 16'h0005, 16'h0005};
        vecs[4]  = '{1'b0, 8'h00, 2'b10, 2'b00, 8'h03, 2'b10, 2'b00, 16'h0305, 16'h0305};
        vecs[5]  = '{1'b1, 8'h07, 2'b00, 2'b00, 8'h07, 2'b10, 2'b00, 16'h0305, 16'h0305};
        vecs[6]  = '{1'b0, 8'h00, 2'b10, 2'b00, 8'h07, 2'b10, 2'b10, 16'h0305, 16'h0705};
        vecs[7]  = '{1'b0, 8'h00, 2'b00, 2'b10, 8'h07, 2'b00, 2'b00, 16'h0305, 16'h0705};
        vecs[8]  = '{1'b1, 8'h09, 2'b00, 2'b00, 8'h09, 2'b00, 2'b00, 16'h0305, 16'h0705};
        vecs[9]  = '{1'b0, 8'h00, 2'b01, 2'b00, 8'h09, 2'b01, 2'b00, 16'h0309, 16'h0709};
        vecs[10] = '{1'b1, 8'h0A, 2'b00, 2'b00, 8'h0A, 2'b01, 2'b00, 16'h0309, 16'h0709};
        vecs[11] = '{1'b0, 8'h00, 2'b01, 2'b00, 8'h0A, 2'b01, 2'b01, 16'h0309, 16'h070A};
        vecs[12] = '{1'b1, 8'h0B, 2'b00, 2'b00, 8'h0B, 2'b01, 2'b01, 16'h0309, 16'h070A};
        vecs[13] = '{1'b0, 8'h00, 2'b01, 2'b01, 8'h0B, 2'b01, 2'b00, 16'h030B, 16'h070B};
        vecs[14] = '{1'b1, 8'h20, 2'b10, 2'b00, 8'h20, 2'b11, 2'b00, 16'h0B0B, 16'h0B0B};
        vecs[15] = '{1'b0, 8'h00, 2'b00, 2'b11, 8'h20, 2'b00, 2'b00, 16'h0B0B, 16'h0B0B};
        vecs[16] = '{1'b0, 8'h00, 2'b00, 2'b01, 8'h20, 2'b00, 2'b00, 16'h0B0B, 16'h0B0B};

        // Reset state
        step(2);
        check("rst ts_a", 32'(ts_a), 32'h0);
        check("rst ts_b", 32'(ts_b), 32'h0);
        check("rst tick_a", 32'(tick_a), 32'h0);
        check("rst roll_a", 32'(roll_a), 32'h0);
        check_chan("rst", 2'b00, 2'b00, 16'h0000, 16'h0000);

        // Prescaled counting: TICK every 4th cycle, 10 after 40 cycles
        RESET = 1'b0;
        EN    = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            check($sformatf("cnt ts_a k=%0d", k), 32'(ts_a), 32'(k / 4));
            check($sformatf("cnt tick_a k=%0d", k), 32'(tick_a), 32'((k % 4) == 0));
        end
        check("cnt ts_b after 40", 32'(ts_b), 32'd10);

        // EN low freezes value and prescaler phase
        EN = 1'b0;
        step(8);
        check("freeze ts_a", 32'(ts_a), 32'd10);
        check("freeze tick_a", 32'(tick_a), 32'h0);
        EN = 1'b1;
        step(3);
        check("resume ts_a pre", 32'(ts_a), 32'd10);
        step(1);
        check("resume ts_a", 32'(ts_a), 32'd11);
        check("resume tick_a", 32'(tick_a), 32'h1);

        // LOAD on the would-be increment edge wins and suppresses TICK
        step(3);
        LOAD     = 1'b1;
        LOAD_VAL = 8'hFE;
        step(1);
        LOAD = 1'b0;
        check("load ts_a", 32'(ts_a), 32'hFE);
        check("load ts_b", 32'(ts_b), 32'hFE);
        check("load tick_a", 32'(tick_a), 32'h0);
        step(3);
        check("load hold ts_a", 32'(ts_a), 32'hFE);
        step(1);
        check("ff ts_a", 32'(ts_a), 32'hFF);
        check("ff roll_a", 32'(roll_a), 32'h0);
        step(4);
        check("wrap ts_a", 32'(ts_a), 32'h00);
        check("wrap tick_a", 32'(tick_a), 32'h1);
        check("wrap roll_a", 32'(roll_a), 32'h1);
        check("sat ts_b", 32'(ts_b), 32'hFF);
        check("sat tick_b", 32'(tick_b), 32'h1);
        check("sat roll_b", 32'(roll_b), 32'h0);
        step(1);
        check("wrap+1 roll_a", 32'(roll_a), 32'h0);
        check("wrap+1 tick_a", 32'(tick_a), 32'h0);
        step(3);
        check("post ts_a", 32'(ts_a), 32'h01);
        check("post ts_b", 32'(ts_b), 32'hFF);
        check("post tick_b", 32'(tick_b), 32'h1);
        check("post roll_b", 32'(roll_b), 32'h0);

        // Table-driven capture vectors
        EN = 1'b0;
        for (int v = 0; v < 17; v++) begin
            LOAD     = vecs[v].ld;
            LOAD_VAL = vecs[v].ld_val;
            CAP_REQ  = vecs[v].req;
            CAP_ACK  = vecs[v].ack;
            step(1);
            check($sformatf("vec%0d ts_a", v), 32'(ts_a), 32'(vecs[v].ts));
            check($sformatf("vec%0d ts_b", v), 32'(ts_b), 32'(vecs[v].ts));
            check_chan($sformatf("vec%0d", v), vecs[v].valid, vecs[v].ovf, vecs[v].da, vecs[v].db);
        end
        LOAD    = 1'b0;
        CAP_ACK = 2'b00;

        // Edge in the increment cycle 0x0C->0x0D captures 0x0C
        LOAD     = 1'b1;
        LOAD_VAL = 8'h0C;
        step(1);
        LOAD = 1'b0;
        EN   = 1'b1;
        step(3);
        CAP_REQ = 2'b01;
        step(1);
        check("inc-edge ts_a", 32'(ts_a), 32'h0D);
        check("inc-edge tick_a", 32'(tick_a), 32'h1);
        check_chan("inc-edge", 2'b01, 2'b00, 16'h0B0C, 16'h0B0C);
        EN      = 1'b0;
        CAP_REQ = 2'b00;
        CAP_ACK = 2'b01;
        step(1);
        CAP_ACK = 2'b00;
        check_chan("inc-ack", 2'b00, 2'b00, 16'h0B0C, 16'h0B0C);

        // Reset mid-run with requests held high
        CAP_REQ = 2'b11;
        step(1);
        check_chan("pre-rst", 2'b11, 2'b00, 16'h0D0D, 16'h0D0D);
        RESET = 1'b1;
        step(2);
        check("mid-rst ts_a", 32'(ts_a), 32'h0);
        check("mid-rst tick_a", 32'(tick_a), 32'h0);
        check_chan("mid-rst", 2'b00, 2'b00, 16'h0000, 16'h0000);
        RESET = 1'b0;
        step(3);
        check_chan("held-req", 2'b00, 2'b00, 16'h0000, 16'h0000);
        CAP_REQ  = 2'b00;
        LOAD     = 1'b1;
        LOAD_VAL = 8'h33;
        step(1);
        LOAD    = 1'b0;
        CAP_REQ = 2'b11;
        step(1);
        check_chan("re-edge", 2'b11, 2'b00, 16'h3333, 16'h3333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
